// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared instruction/data memory port.
// Each access takes one IDLE grant cycle, MEM_LAT BUSY cycles, and one RESP cycle.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] rdata,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        last_gnt_q, last_gnt_d;
  logic        we_q, we_d;
  logic        mem_we_q, mem_we_d;
  logic        m0_ready_q, m0_ready_d;
  logic        m1_ready_q, m1_ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_adr_q, mem_adr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        pick;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    m0_ready_d  = 1'b0;
    m1_ready_d  = 1'b0;
    pick        = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On conflict the requester that was not served last wins.
          pick        = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
          gnt_d       = pick;
          last_gnt_d  = pick;
          mem_adr_d   = pick ? m1_adr   : m0_adr;
          mem_wdata_d = pick ? m1_wdata : m0_wdata;
          we_d        = pick ? m1_we    : m0_we;
          // Registered strobe lands in the first BUSY cycle only.
          mem_we_d    = pick ? m1_we    : m0_we;
          cnt_d       = LAT_CNT;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          m0_ready_d = ~gnt_q;
          m1_ready_d = gnt_q;
          state_d    = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      we_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      m0_ready_q  <= 1'b0;
      m1_ready_q  <= 1'b0;
      rdata_q     <= 32'd0;
      mem_adr_q   <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      we_q        <= we_d;
      mem_we_q    <= mem_we_d;
      m0_ready_q  <= m0_ready_d;
      m1_ready_q  <= m1_ready_d;
      rdata_q     <= rdata_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign rdata     = rdata_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1, 3, 15) checked every cycle
// against a timeline model of each access (grant cycle plus offset), with directed and random traffic.
module tb_mem_port_arbiter;

  localparam int NI = 3;
  localparam int LATS [NI] = '{1, 3, 15};

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_s  [NI];
  logic        m0_req   [NI];
  logic        m0_we    [NI];
  logic [31:0] m0_adr   [NI];
  logic [31:0] m0_wdata [NI];
  logic        m1_req   [NI];
  logic        m1_we    [NI];
  logic [31:0] m1_adr   [NI];
  logic [31:0] m1_wdata [NI];
  logic        m0_ready [NI];
  logic        m1_ready [NI];
  logic [31:0] rdata    [NI];
  logic [31:0] mem_adr  [NI];
  logic [31:0] mem_wdata[NI];
  logic        mem_we   [NI];
  logic [31:0] mem_rdata[NI];
  logic        busy     [NI];
  logic [31:0] mem_arr  [16];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      assign mem_rdata[gi] = mem_arr[mem_adr[gi][5:2]];
      mem_port_arbiter #(.MEM_LAT(LATS[gi])) u_dut (
        .clk      (clk),
        .reset    (reset_s[gi]),
        .m0_req   (m0_req[gi]),
        .m0_we    (m0_we[gi]),
        .m0_adr   (m0_adr[gi]),
        .m0_wdata (m0_wdata[gi]),
        .m0_ready (m0_ready[gi]),
        .m1_req   (m1_req[gi]),
        .m1_we    (m1_we[gi]),
        .m1_adr   (m1_adr[gi]),
        .m1_wdata (m1_wdata[gi]),
        .m1_ready (m1_ready[gi]),
        .rdata    (rdata[gi]),
        .mem_adr  (mem_adr[gi]),
        .mem_wdata(mem_wdata[gi]),
        .mem_we   (mem_we[gi]),
        .mem_rdata(mem_rdata[gi]),
        .busy     (busy[gi])
      );
    end
  endgenerate

  // Reference model: one record per instance for the access in flight, timed from its grant cycle.
  bit          has_acc [NI];
  int          g_cyc   [NI];
  bit          a_who   [NI];
  txn_t        a_txn   [NI];
  bit          last    [NI];
  bit          mvalid  [NI];
  bit          rst_req [NI];
  logic [31:0] e_adr   [NI];
  logic [31:0] e_wdata [NI];
  logic [31:0] e_rdata [NI];
  txn_t        q       [2*NI][$];
  int          rdy_log [NI][$];
  int          rdy_cyc [NI];
  int          cyc;
  int          n_chk;
  int          n_err;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s inst=%0d cyc=%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] adr, input logic [31:0] wdata);
    txn_t x;
    x.we = we;
    x.adr = adr;
    x.wdata = wdata;
    return x;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom_range(0, 1)), $urandom, $urandom);
  endfunction

  task automatic present(input int i);
    if (q[2*i].size() > 0) begin
      m0_req[i]   = 1'b1;
      m0_we[i]    = q[2*i][0].we;
      m0_adr[i]   = q[2*i][0].adr;
      m0_wdata[i] = q[2*i][0].wdata;
    end else begin
      m0_req[i] = 1'b0;
    end
    if (q[2*i+1].size() > 0) begin
      m1_req[i]   = 1'b1;
      m1_we[i]    = q[2*i+1][0].we;
      m1_adr[i]   = q[2*i+1][0].adr;
      m1_wdata[i] = q[2*i+1][0].wdata;
    end else begin
      m1_req[i] = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      bit rst_prev;
      int t;
      int lat;
      bit e_busy, e_we, e_r0, e_r1;
      lat = LATS[i];
      rst_prev = reset_s[i];
      if (rst_prev) begin
        has_acc[i] = 1'b0;
        last[i]    = 1'b1;
        e_adr[i]   = 32'd0;
        e_wdata[i] = 32'd0;
        e_rdata[i] = 32'd0;
        mvalid[i]  = 1'b1;
        q[2*i].delete();
        q[2*i+1].delete();
      end
      t      = has_acc[i] ? (cyc - g_cyc[i]) : 0;
      e_busy = has_acc[i] && (t >= 1) && (t <= lat + 1);
      e_we   = has_acc[i] && (t == 1) && a_txn[i].we;
      e_r0   = has_acc[i] && (t == lat + 1) && !a_who[i];
      e_r1   = has_acc[i] && (t == lat + 1) && a_who[i];
      if (has_acc[i] && t == 1) begin
        e_adr[i]   = a_txn[i].adr;
        e_wdata[i] = a_txn[i].wdata;
      end
      if (has_acc[i] && t == lat + 1 && !a_txn[i].we) begin
        e_rdata[i] = mem_arr[a_txn[i].adr[5:2]];
      end
      if (mvalid[i]) begin
        chk("busy",      i, 32'(busy[i]),     32'(e_busy));
        chk("mem_we",    i, 32'(mem_we[i]),   32'(e_we));
        chk("m0_ready",  i, 32'(m0_ready[i]), 32'(e_r0));
        chk("m1_ready",  i, 32'(m1_ready[i]), 32'(e_r1));
        chk("mem_adr",   i, mem_adr[i],       e_adr[i]);
        chk("mem_wdata", i, mem_wdata[i],     e_wdata[i]);
        chk("rdata",     i, rdata[i],         e_rdata[i]);
      end
      if (m0_ready[i] === 1'b1) begin
        rdy_log[i].push_back(0);
        rdy_cyc[i] = cyc;
        if (q[2*i].size() > 0) void'(q[2*i].pop_front());
      end
      if (m1_ready[i] === 1'b1) begin
        rdy_log[i].push_back(1);
        rdy_cyc[i] = cyc;
        if (q[2*i+1].size() > 0) void'(q[2*i+1].pop_front());
      end
      present(i);
      reset_s[i] = rst_req[i];
      if (!reset_s[i] && mvalid[i] && (!has_acc[i] || t >= lat + 2) && (m0_req[i] || m1_req[i])) begin
        a_who[i]   = (m0_req[i] && m1_req[i]) ? !last[i] : m1_req[i];
        a_txn[i]   = a_who[i] ? mk(m1_we[i], m1_adr[i], m1_wdata[i]) : mk(m0_we[i], m0_adr[i], m0_wdata[i]);
        last[i]    = a_who[i];
        has_acc[i] = 1'b1;
        g_cyc[i]   = cyc;
      end
    end
  endtask

  task automatic drain(input int i, input int budget);
    int k;
    k = 0;
    while ((q[2*i].size() > 0 || q[2*i+1].size() > 0 || busy[i] !== 1'b0) && k < budget) begin
      step();
      k++;
    end
    chk("drain_timeout", i, 32'(k < budget), 32'd1);
  endtask

  initial begin
    int t0;
    int cnt;
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    for (int k = 0; k < 16; k++) mem_arr[k] = $urandom;
    mem_arr[4] = 32'hDEAD_BEEF;
    mem_arr[8] = 32'hCAFE_0001;
    for (int i = 0; i < NI; i++) begin
      reset_s[i] = 1'b1;  rst_req[i] = 1'b1;
      m0_req[i] = 1'b0;   m0_we[i] = 1'b0;  m0_adr[i] = 32'd0;  m0_wdata[i] = 32'd0;
      m1_req[i] = 1'b0;   m1_we[i] = 1'b0;  m1_adr[i] = 32'd0;  m1_wdata[i] = 32'd0;
      has_acc[i] = 1'b0;  last[i] = 1'b1;   mvalid[i] = 1'b0;   rdy_cyc[i] = -1;
    end
    step();
    step();
    for (int i = 0; i < NI; i++) rst_req[i] = 1'b0;
    step();

    // Single m0 read, MEM_LAT=1.
    t0 = cyc + 1;
    q[0].push_back(mk(1'b0, 32'h0000_0010, 32'd0));
    drain(0, 50);
    chk("t1_rdata", 0, rdata[0], 32'hDEAD_BEEF);
    chk("t1_ready_lat", 0, 32'(rdy_cyc[0] - t0), 32'd2);

    // m1 write, MEM_LAT=3: one strobe, ready four cycles after the request is sampled.
    t0 = cyc + 1;
    cnt = 0;
    q[3].push_back(mk(1'b1, 32'h0000_0040, 32'h1234_5678));
    repeat (8) begin
      step();
      if (mem_we[1] === 1'b1) cnt++;
    end
    chk("t2_we_cycles", 1, 32'(cnt), 32'd1);
    chk("t2_ready_lat", 1, 32'(rdy_cyc[1] - t0), 32'd4);
    chk("t2_rdata", 1, rdata[1], 32'd0);

    // Both requesters after reset, two accesses each: grants alternate starting with m0.
    rst_req[0] = 1'b1;
    step();
    step();
    rst_req[0] = 1'b0;
    step();
    rdy_log[0].delete();
    q[0].push_back(mk(1'b0, 32'h0000_0004, 32'd0));
    q[0].push_back(mk(1'b1, 32'h0000_0008, 32'hAAAA_0001));
    q[1].push_back(mk(1'b0, 32'h0000_000C, 32'd0));
    q[1].push_back(mk(1'b1, 32'h0000_0014, 32'hBBBB_0002));
    drain(0, 100);
    chk("t3_count", 0, 32'(rdy_log[0].size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t3_order", 0, (rdy_log[0].size() > k) ? 32'(rdy_log[0][k]) : 32'hFFFF_FFFF, 32'(k % 2));
    end

    // m1 arrives while m0 is in BUSY; it waits for the next IDLE cycle.
    rdy_log[1].delete();
    q[2].push_back(mk(1'b0, 32'h0000_0008, 32'd0));
    step();
    step();
    q[3].push_back(mk(1'b0, 32'h0000_000C, 32'd0));
    drain(1, 60);
    chk("t4_first",  1, (rdy_log[1].size() > 0) ? 32'(rdy_log[1][0]) : 32'hFFFF_FFFF, 32'd0);
    chk("t4_second", 1, (rdy_log[1].size() > 1) ? 32'(rdy_log[1][1]) : 32'hFFFF_FFFF, 32'd1);

    // Reset in the second BUSY cycle of a write drops it; next conflict goes to m0.
    q[3].push_back(mk(1'b1, 32'h0000_0040, 32'h55AA_55AA));
    step();
    step();
    rst_req[1] = 1'b1;
    step();
    rst_req[1] = 1'b0;
    step();
    chk("t5_busy",  1, 32'(busy[1]),     32'd0);
    chk("t5_we",    1, 32'(mem_we[1]),   32'd0);
    chk("t5_rdy1",  1, 32'(m1_ready[1]), 32'd0);
    rdy_log[1].delete();
    q[2].push_back(mk(1'b0, 32'h0000_0010, 32'd0));
    q[3].push_back(mk(1'b0, 32'h0000_0020, 32'd0));
    drain(1, 60);
    chk("t5_first", 1, (rdy_log[1].size() > 0) ? 32'(rdy_log[1][0]) : 32'hFFFF_FFFF, 32'd0);

    // MEM_LAT=15 read: busy covers the 15 BUSY cycles plus RESP (the grant cycle is IDLE).
    t0 = cyc + 1;
    cnt = 0;
    q[4].push_back(mk(1'b0, 32'h0000_0020, 32'd0));
    repeat (25) begin
      step();
      if (busy[2] === 1'b1) cnt++;
    end
    chk("t6_ready_lat", 2, 32'(rdy_cyc[2] - t0), 32'd16);
    chk("t6_busy_cycles", 2, 32'(cnt), 32'd16);
    chk("t6_rdata", 2, rdata[2], 32'hCAFE_0001);

    // Random traffic with occasional resets on each instance.
    for (int i = 0; i < NI; i++) begin
      repeat (300) begin
        for (int r = 0; r < 2; r++) begin
          if (q[2*i+r].size() == 0 && $urandom_range(0, 3) == 0) q[2*i+r].push_back(rand_txn());
        end
        rst_req[i] = ($urandom_range(0, 79) == 0);
        step();
      end
      rst_req[i] = 1'b0;
      drain(i, 100);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
